// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage datapath: datapath width and ALU opcodes.
// Only WIDTH = 4 is supported.
package alu_pkg;

   localparam int WIDTH = 4;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_PASSB = 4'b0111;
   localparam logic [3:0] OP_NOR   = 4'b1100;

endpackage

// File: rtl/alu_datapath_if.sv
// Bundle between the control decoder / memory side and the execute-stage datapath.
// The master modport is the control side; the slave modport is the datapath.
interface alu_datapath_if;
   import alu_pkg::*;

   logic             en;
   logic [WIDTH-1:0] rx;
   logic [WIDTH-1:0] ry;
   logic [WIDTH-1:0] immediate;
   logic             alu_src;
   logic [3:0]       alu_opcode;
   logic [WIDTH-1:0] read_data;
   logic             mem_to_reg;
   logic [WIDTH-1:0] alu_result;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic [WIDTH-1:0] rz;

   modport master (
      output en, rx, ry, immediate, alu_src, alu_opcode, read_data, mem_to_reg,
      input  alu_result, zero, carry, overflow, rz
   );

   modport slave (
      input  en, rx, ry, immediate, alu_src, alu_opcode, read_data, mem_to_reg,
      output alu_result, zero, carry, overflow, rz
   );

endinterface

// File: rtl/alu_core.sv
// Purely combinational 4-bit ALU: result, carry / no-borrow, and signed overflow.
// Unknown or undefined opcodes fall into the default row (all zero).
module alu_core
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] r,
   output logic             c,
   output logic             v
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      r = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         OP_AND:   r = a & b;
         OP_OR:    r = a | b;
         OP_ADD: begin
            r = sum[WIDTH-1:0];
            c = sum[WIDTH];
            v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_XOR:   r = a ^ b;
         OP_SUB: begin
            // The borrow bit of the widened difference is set exactly when a < b.
            r = diff[WIDTH-1:0];
            c = ~diff[WIDTH];
            v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_PASSB: r = b;
         OP_NOR:   r = ~(a | b);
         default: begin
            r = '0;
            c = 1'b0;
            v = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_datapath.sv
// Execute stage: operand-B select, registered ALU result and flags, and the
// combinational write-back select feeding the register file.
module alu_datapath
   import alu_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   alu_datapath_if.slave bus
);

   logic [WIDTH-1:0] operand_b;
   logic [WIDTH-1:0] core_r;
   logic             core_c;
   logic             core_v;

   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             carry_q;
   logic             overflow_q;

   // Selects compare against 1 so an unknown select falls to the 0 input.
   always_comb begin
      if (bus.alu_src == 1'b1) operand_b = bus.immediate;
      else                     operand_b = bus.ry;
   end

   alu_core u_core (
      .a  (bus.rx),
      .b  (operand_b),
      .op (bus.alu_opcode),
      .r  (core_r),
      .c  (core_c),
      .v  (core_v)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         result_q   <= '0;
         zero_q     <= 1'b1;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else if (bus.en == 1'b1) begin
         result_q   <= core_r;
         zero_q     <= (core_r == '0);
         carry_q    <= core_c;
         overflow_q <= core_v;
      end
   end

   // Write-back uses the registered result, so memory data bypasses the ALU latency.
   always_comb begin
      if (bus.mem_to_reg == 1'b1) bus.rz = bus.read_data;
      else                        bus.rz = result_q;
   end

   assign bus.alu_result = result_q;
   assign bus.zero       = zero_q;
   assign bus.carry      = carry_q;
   assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: directed vector table, hand-written
// reset / write-back / hold sequences, and random stimulus against an arithmetic model.
module tb_alu_datapath;
   import alu_pkg::*;

   typedef struct {
      string      name;
      logic [3:0] op;
      logic [3:0] rx;
      logic [3:0] ry;
      logic [3:0] imm;
      logic       src;
      logic [3:0] r;
      logic       z;
      logic       c;
      logic       v;
   } vec_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   int   passed  = 0;
   int   total   = 0;

   alu_datapath_if bus ();

   alu_datapath dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
      total++;
      if (actual === expected) passed++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
   endtask

   task automatic apply_stimulus(input logic [3:0] op, input logic [3:0] rx, input logic [3:0] ry,
                                 input logic [3:0] imm, input logic src, input logic en);
      bus.alu_opcode = op;
      bus.rx         = rx;
      bus.ry         = ry;
      bus.immediate  = imm;
      bus.alu_src    = src;
      bus.en         = en;
      @(posedge clock);
      #1;
   endtask

   task automatic check_regs(input string name, input logic [3:0] r, input logic z,
                             input logic c, input logic v);
      check_output({name, ".result"},   {4'h0, bus.alu_result}, {4'h0, r});
      check_output({name, ".zero"},     {7'h0, bus.zero},       {7'h0, z});
      check_output({name, ".carry"},    {7'h0, bus.carry},      {7'h0, c});
      check_output({name, ".overflow"}, {7'h0, bus.overflow},   {7'h0, v});
   endtask

   // Reference model from signed/unsigned arithmetic rather than bit tricks.
   function automatic void ref_alu(input int op, input int a, input int b,
                                   output int r, output int c, output int v);
      int sa, sb, s;
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      r = 0; c = 0; v = 0;
      case (op)
         0:  r = a & b;
         1:  r = a | b;
         2: begin
            r = (a + b) % 16;
            c = (a + b >= 16) ? 1 : 0;
            s = sa + sb;
            v = (s > 7 || s < -8) ? 1 : 0;
         end
         3:  r = a ^ b;
         6: begin
            r = (a - b + 16) % 16;
            c = (a >= b) ? 1 : 0;
            s = sa - sb;
            v = (s > 7 || s < -8) ? 1 : 0;
         end
         7:  r = b;
         12: r = 15 - (a | b);
         default: r = 0;
      endcase
   endfunction

   vec_t vecs[15];

   initial begin
      int m_r, m_c, m_v;
      int exp_r, exp_z, exp_c, exp_v;

      vecs[0]  = '{"add_wrap",   OP_ADD,   4'd7, 4'd9, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0};
      vecs[1]  = '{"add_ovf",    OP_ADD,   4'd7, 4'd1, 4'd0, 1'b0, 4'd8,  1'b0, 1'b0, 1'b1};
      vecs[2]  = '{"add_imm",    OP_ADD,   4'd1, 4'd5, 4'd2, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0};
      vecs[3]  = '{"add_reg",    OP_ADD,   4'd1, 4'd5, 4'd2, 1'b0, 4'd6,  1'b0, 1'b0, 1'b0};
      vecs[4]  = '{"sub_eq",     OP_SUB,   4'd3, 4'd3, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0};
      vecs[5]  = '{"sub_borrow", OP_SUB,   4'd2, 4'd5, 4'd0, 1'b0, 4'd13, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{"and",        OP_AND,   4'hC, 4'hA, 4'h0, 1'b0, 4'h8,  1'b0, 1'b0, 1'b0};
      vecs[7]  = '{"or",         OP_OR,    4'hC, 4'hA, 4'h0, 1'b0, 4'hE,  1'b0, 1'b0, 1'b0};
      vecs[8]  = '{"xor",        OP_XOR,   4'hC, 4'hA, 4'h0, 1'b0, 4'h6,  1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"nor",        OP_NOR,   4'hC, 4'hA, 4'h0, 1'b0, 4'h1,  1'b0, 1'b0, 1'b0};
      vecs[10] = '{"passb",      OP_PASSB, 4'hC, 4'hA, 4'h0, 1'b0, 4'hA,  1'b0, 1'b0, 1'b0};
      vecs[11] = '{"undef_op",   4'b1010,  4'hC, 4'hA, 4'h0, 1'b0, 4'h0,  1'b1, 1'b0, 1'b0};
      vecs[12] = '{"sub_ovf",    OP_SUB,   4'd8, 4'd1, 4'd0, 1'b0, 4'd7,  1'b0, 1'b1, 1'b1};
      vecs[13] = '{"add_neg",    OP_ADD,   4'd8, 4'd8, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1};
      vecs[14] = '{"passb_imm",  OP_PASSB, 4'h3, 4'h9, 4'h5, 1'b1, 4'h5,  1'b0, 1'b0, 1'b0};

      bus.en = 1'b0; bus.rx = '0; bus.ry = '0; bus.immediate = '0; bus.alu_src = 1'b0;
      bus.alu_opcode = OP_AND; bus.read_data = '0; bus.mem_to_reg = 1'b0;

      #1 reset_n = 1'b0;
      #2;
      check_regs("por", 4'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].op, vecs[i].rx, vecs[i].ry, vecs[i].imm, vecs[i].src, 1'b1);
         check_regs(vecs[i].name, vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].v);
         check_output({vecs[i].name, ".rz"}, {4'h0, bus.rz}, {4'h0, vecs[i].r});
      end

      // Mid-cycle asynchronous reset, and reset dominating en.
      apply_stimulus(OP_ADD, 4'd2, 4'd3, 4'd0, 1'b0, 1'b1);
      check_output("pre_reset.result", {4'h0, bus.alu_result}, 8'h05);
      #2 reset_n = 1'b0;
      #1;
      check_regs("async_reset", 4'd0, 1'b1, 1'b0, 1'b0);
      check_output("async_reset.rz", {4'h0, bus.rz}, 8'h00);
      apply_stimulus(OP_ADD, 4'd2, 4'd3, 4'd0, 1'b0, 1'b1);
      check_regs("reset_vs_en", 4'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      apply_stimulus(OP_ADD, 4'd2, 4'd3, 4'd0, 1'b0, 1'b1);
      check_output("first_capture.result", {4'h0, bus.alu_result}, 8'h05);

      // Write-back select and hold.
      apply_stimulus(OP_ADD, 4'd1, 4'd3, 4'd0, 1'b0, 1'b1);
      bus.read_data  = 4'hB;
      bus.mem_to_reg = 1'b1;
      #1;
      check_output("wb_mem.rz", {4'h0, bus.rz}, 8'h0B);
      bus.mem_to_reg = 1'b0;
      #1;
      check_output("wb_alu.rz", {4'h0, bus.rz}, 8'h04);
      apply_stimulus(OP_SUB, 4'd9, 4'd15, 4'd0, 1'b0, 1'b0);
      apply_stimulus(OP_SUB, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0);
      check_regs("hold", 4'd4, 1'b0, 1'b0, 1'b0);
      check_output("hold.rz", {4'h0, bus.rz}, 8'h04);

      // Random stimulus against the model; a mix of defined and arbitrary opcodes.
      exp_r = 4; exp_z = 0; exp_c = 0; exp_v = 0;
      for (int n = 0; n < 300; n++) begin
         logic [3:0] op, a, rb, im, rd;
         logic       src, en, m2r;
         int         bval;
         op  = ($urandom_range(0, 3) == 0) ? 4'($urandom) :
               4'(($urandom_range(0, 6) == 6) ? 12 : (($urandom_range(0, 1) == 1) ?
                  $urandom_range(0, 3) : $urandom_range(6, 7)));
         a   = 4'($urandom);
         rb  = 4'($urandom);
         im  = 4'($urandom);
         rd  = 4'($urandom);
         src = 1'($urandom);
         en  = ($urandom_range(0, 3) != 0);
         m2r = 1'($urandom);
         bus.read_data  = rd;
         bus.mem_to_reg = m2r;
         apply_stimulus(op, a, rb, im, src, en);
         bval = src ? int'(im) : int'(rb);
         if (en) begin
            ref_alu(int'(op), int'(a), bval, m_r, m_c, m_v);
            exp_r = m_r; exp_c = m_c; exp_v = m_v;
            exp_z = (m_r == 0) ? 1 : 0;
         end
         check_regs("random", 4'(exp_r), 1'(exp_z), 1'(exp_c), 1'(exp_v));
         check_output("random.rz", {4'h0, bus.rz}, m2r ? {4'h0, rd} : 8'(exp_r));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
